// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divide sequencer that sits between the CPU
// execute stage and the 32-cycle restoring divider core.
package div_ctrl_pkg;

  localparam int DIV_W       = 32;
  localparam int DIV_LATENCY = 37;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_WAIT,
    ST_FIX,
    ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// CPU-side divide request/result bundle. The CPU (master) drives the request and
// operands; the sequencer (slave) returns stall, completion strobes and HI/LO.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic             req;
  logic             is_signed;
  logic [DIV_W-1:0] dividend;
  logic [DIV_W-1:0] divisor;
  logic             stall;
  logic             done;
  logic             hilo_we;
  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] lo;
  logic             div_zero_exc;

  modport master (
    output req, is_signed, dividend, divisor,
    input  stall, done, hilo_we, hi, lo, div_zero_exc
  );

  modport slave (
    input  req, is_signed, dividend, divisor,
    output stall, done, hilo_we, hi, lo, div_zero_exc
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of a pair of words. Used to take operand
// magnitudes before the core and to restore quotient/remainder signs after it.
module div_sign_fix
  import div_ctrl_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] a_in,
  input  logic         neg_a,
  input  logic [W-1:0] b_in,
  input  logic         neg_b,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out
);

  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
  assign a_out = neg_a ? -a_in : a_in;
  assign b_out = neg_b ? -b_in : b_in;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: conditions operands, drives the core start pulse, waits on busy,
// sign-corrects q/r into HI/LO and stalls the pipeline. Optional: DIV_ZERO_TRAP_EN.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clock,
  input  logic         reset,
  div_ctrl_if.slave    cpu,
  output logic         div_start,
  output logic [W-1:0] div_dividend,
  output logic [W-1:0] div_divisor,
  input  logic         div_busy,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r
);

  div_state_e state_q, state_d;

  logic         sign_a_q, sign_b_q;
  logic [W-1:0] hi_q, lo_q;
  logic [W-1:0] op_a_mag, op_b_mag;
  logic [W-1:0] lo_fix, hi_fix;
  logic         op_neg_a, op_neg_b;
  logic         accept;
  logic         req_zero;
  logic         zero_trap_q;

  assign accept   = cpu.req && (state_q == ST_IDLE);
  assign op_neg_a = cpu.is_signed & cpu.dividend[W-1];
  assign op_neg_b = cpu.is_signed & cpu.divisor[W-1];

  div_sign_fix #(.W(W)) u_op_fix (
    .a_in  (cpu.dividend),
    .neg_a (op_neg_a),
    .b_in  (cpu.divisor),
    .neg_b (op_neg_b),
    .a_out (op_a_mag),
    .b_out (op_b_mag)
  );

  // Quotient is negative when operand signs differ; remainder takes the dividend's sign.
  div_sign_fix #(.W(W)) u_res_fix (
    .a_in  (div_q),
    .neg_a (sign_a_q ^ sign_b_q),
    .b_in  (div_r),
    .neg_b (sign_a_q),
    .a_out (lo_fix),
    .b_out (hi_fix)
  );

`ifdef DIV_ZERO_TRAP_EN
  assign req_zero = (cpu.divisor == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero_trap_q <= 1'b0;
    end else if (accept) begin
      zero_trap_q <= req_zero;
    end
  end
`else
  assign req_zero    = 1'b0;
  assign zero_trap_q = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sign_a_q     <= op_neg_a;
        sign_b_q     <= op_neg_b;
        div_dividend <= op_a_mag;
        div_divisor  <= op_b_mag;
      end
      if (state_q == ST_FIX) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
  end

  assign cpu.hi = hi_q;
  assign cpu.lo = lo_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    div_start        = 1'b0;
    cpu.done         = 1'b0;
    cpu.hilo_we      = 1'b0;
    cpu.div_zero_exc = 1'b0;
    cpu.stall        = (state_q != ST_IDLE) && (state_q != ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        cpu.stall = cpu.req;
        if (cpu.req) state_d = req_zero ? ST_DONE : ST_START;
      end
      ST_START: begin
        div_start = 1'b1;
        state_d   = ST_ARM;
      end
      // The core latches operands on the falling edge of start, i.e. at the end of ARM.
      ST_ARM:  state_d = ST_WAIT;
      ST_WAIT: if (!div_busy) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        cpu.done         = 1'b1;
        cpu.hilo_we      = !zero_trap_q;
        cpu.div_zero_exc = zero_trap_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural 32-cycle divider core, directed vector
// table, plus hand sequences for reset mid-divide, foreign busy and back-to-back requests.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clock;
  logic        reset;
  logic        div_start;
  logic [31:0] div_dividend, div_divisor;
  logic        div_busy;
  logic [31:0] div_q, div_r;

  logic        core_busy;
  logic        ext_busy;
  logic        start_d;
  int          core_cnt;
  logic [31:0] core_a, core_b;

  int n_checks = 0;
  int n_fail   = 0;

  div_ctrl_if cpu_if ();

  div_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .cpu          (cpu_if),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign div_busy = core_busy | ext_busy;

  // Behavioural core: latches on start 1->0, busy for 32 cycles, then q/r valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_d   <= 1'b0;
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_a    <= '0;
      core_b    <= '0;
      div_q     <= '0;
      div_r     <= '0;
    end else begin
      start_d <= div_start;
      if (start_d && !div_start) begin
        core_busy <= 1'b1;
        core_cnt  <= 32;
        core_a    <= div_dividend;
        core_b    <= div_divisor;
      end else if (core_busy) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          core_busy <= 1'b0;
          div_q     <= (core_b == '0) ? 32'hFFFF_FFFF : core_a / core_b;
          div_r     <= (core_b == '0) ? core_a : core_a % core_b;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues a request and observes ncyc cycles (cycle 0 = request cycle). req is held for
  // hold_cyc cycles; with hold_cyc > 1 the operands switch to the second set at cycle 5.
  task automatic run_op(
    input  logic        s,  input logic [31:0] a,  input logic [31:0] b,
    input  int          hold_cyc,
    input  logic        s2, input logic [31:0] a2, input logic [31:0] b2,
    input  int          ncyc, input int lat, input bit two,
    output int          done1, output int done2,
    output int          we_n, output int exc_n, output int start_n, output int stall_bad,
    output logic [31:0] lo1, output logic [31:0] hi1,
    output logic [31:0] lo2, output logic [31:0] hi2
  );
    logic exp_stall;
    done1 = -1; done2 = -1; we_n = 0; exc_n = 0; start_n = 0; stall_bad = 0;
    lo1 = 'x; hi1 = 'x; lo2 = 'x; hi2 = 'x;
    @(negedge clock);
    cpu_if.req = 1'b1; cpu_if.is_signed = s; cpu_if.dividend = a; cpu_if.divisor = b;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      exp_stall = (c < lat) || (two && c >= lat + 1 && c < 2 * lat + 1);
      if (cpu_if.stall !== exp_stall) stall_bad++;
      if (cpu_if.done === 1'b1) begin
        if (done1 < 0) begin
          done1 = c; lo1 = cpu_if.lo; hi1 = cpu_if.hi;
        end else if (done2 < 0) begin
          done2 = c; lo2 = cpu_if.lo; hi2 = cpu_if.hi;
        end
      end
      we_n    += int'(cpu_if.hilo_we);
      exc_n   += int'(cpu_if.div_zero_exc);
      start_n += int'(div_start);
      @(negedge clock);
      if (c == 5 && hold_cyc > 1) begin
        cpu_if.is_signed = s2; cpu_if.dividend = a2; cpu_if.divisor = b2;
      end
      if (c == hold_cyc - 1) cpu_if.req = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] a, b;
    logic [31:0] lo, hi;
    int          lat;
    int          we, exc, starts;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d1, d2, wn, en, sn, sb;
    logic [31:0] l1, h1, l2, h2;

    vecs[0]  = '{"divu_100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         37, 1, 0, 1};
    vecs[1]  = '{"div_m7_2",      1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 37, 1, 0, 1};
    vecs[2]  = '{"div_7_m2",      1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         37, 1, 0, 1};
    vecs[3]  = '{"div_ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         37, 1, 0, 1};
`ifdef DIV_ZERO_TRAP_EN
    vecs[4]  = '{"divu_5_0",      1'b0, 32'd5,         32'd0,         32'h8000_0000, 32'd0,         1,  0, 1, 0};
`else
    vecs[4]  = '{"divu_5_0",      1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         37, 1, 0, 1};
`endif
    vecs[5]  = '{"divu_max_1",    1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         37, 1, 0, 1};
    vecs[6]  = '{"div_m100_m7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 37, 1, 0, 1};
    vecs[7]  = '{"divu_min_max",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 37, 1, 0, 1};
    vecs[8]  = '{"div_min_2",     1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         37, 1, 0, 1};
`ifdef DIV_ZERO_TRAP_EN
    vecs[9]  = '{"div_m5_0",      1'b1, 32'hFFFF_FFFB, 32'd0,         32'hC000_0000, 32'd0,         1,  0, 1, 0};
`else
    vecs[9]  = '{"div_m5_0",      1'b1, 32'hFFFF_FFFB, 32'd0,         32'd1,         32'hFFFF_FFFB, 37, 1, 0, 1};
`endif
    vecs[10] = '{"divu_0_3",      1'b0, 32'd0,         32'd3,         32'd0,         32'd0,         37, 1, 0, 1};

    cpu_if.req = 1'b0; cpu_if.is_signed = 1'b0; cpu_if.dividend = '0; cpu_if.divisor = '0;
    ext_busy = 1'b0;
    reset = 1'b0;
    #23;
    check("reset_stall", 32'(cpu_if.stall), 32'd0);
    check("reset_done",  32'(cpu_if.done), 32'd0);
    check("reset_we",    32'(cpu_if.hilo_we), 32'd0);
    check("reset_hi",    cpu_if.hi, 32'd0);
    check("reset_lo",    cpu_if.lo, 32'd0);
    check("reset_start", 32'(div_start), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, 1, 1'b0, '0, '0,
             vecs[i].lat + 4, vecs[i].lat, 1'b0,
             d1, d2, wn, en, sn, sb, l1, h1, l2, h2);
      check({vecs[i].name, "_done_cycle"}, 32'(d1), 32'(vecs[i].lat));
      check({vecs[i].name, "_lo"},         l1, vecs[i].lo);
      check({vecs[i].name, "_hi"},         h1, vecs[i].hi);
      check({vecs[i].name, "_hilo_we_n"},  32'(wn), 32'(vecs[i].we));
      check({vecs[i].name, "_exc_n"},      32'(en), 32'(vecs[i].exc));
      check({vecs[i].name, "_start_n"},    32'(sn), 32'(vecs[i].starts));
      check({vecs[i].name, "_stall_errs"}, 32'(sb), 32'd0);
    end

    // Reset asserted 20 cycles into a divide clears everything at once.
    @(negedge clock);
    cpu_if.req = 1'b1; cpu_if.is_signed = 1'b0; cpu_if.dividend = 32'd100; cpu_if.divisor = 32'd7;
    @(negedge clock);
    cpu_if.req = 1'b0;
    repeat (19) @(negedge clock);
    #1;
    check("midop_stall_before_reset", 32'(cpu_if.stall), 32'd1);
    reset = 1'b0;
    #1;
    check("midop_rst_stall",    32'(cpu_if.stall), 32'd0);
    check("midop_rst_done",     32'(cpu_if.done), 32'd0);
    check("midop_rst_we",       32'(cpu_if.hilo_we), 32'd0);
    check("midop_rst_exc",      32'(cpu_if.div_zero_exc), 32'd0);
    check("midop_rst_hi",       cpu_if.hi, 32'd0);
    check("midop_rst_lo",       cpu_if.lo, 32'd0);
    check("midop_rst_start",    32'(div_start), 32'd0);
    check("midop_rst_dividend", div_dividend, 32'd0);
    check("midop_rst_divisor",  div_divisor, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op(1'b0, 32'd9, 32'd3, 1, 1'b0, '0, '0, 41, 37, 1'b0,
           d1, d2, wn, en, sn, sb, l1, h1, l2, h2);
    check("post_rst_done_cycle", 32'(d1), 32'd37);
    check("post_rst_lo",         l1, 32'd3);
    check("post_rst_hi",         h1, 32'd0);
    check("post_rst_we_n",       32'(wn), 32'd1);

    // A busy core that is not ours must not start anything while idle.
    sn = 0; sb = 0;
    @(negedge clock);
    ext_busy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      sn += int'(div_start);
      sb += int'(cpu_if.stall) + int'(cpu_if.done);
      @(negedge clock);
    end
    ext_busy = 1'b0;
    check("foreign_busy_starts", 32'(sn), 32'd0);
    check("foreign_busy_activity", 32'(sb), 32'd0);

    // req held through DONE: second op (DIV -9/3) accepted only in the following IDLE cycle.
    run_op(1'b0, 32'd100, 32'd7, 39, 1'b1, 32'hFFFF_FFF7, 32'd3, 80, 37, 1'b1,
           d1, d2, wn, en, sn, sb, l1, h1, l2, h2);
    check("b2b_done1_cycle", 32'(d1), 32'd37);
    check("b2b_lo1",         l1, 32'd14);
    check("b2b_hi1",         h1, 32'd2);
    check("b2b_done2_cycle", 32'(d2), 32'd75);
    check("b2b_lo2",         l2, 32'hFFFF_FFFD);
    check("b2b_hi2",         h2, 32'd0);
    check("b2b_we_n",        32'(wn), 32'd2);
    check("b2b_start_n",     32'(sn), 32'd2);
    check("b2b_stall_errs",  32'(sb), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
